// File: rtl/cksum_update_pkg.sv
// Shared types for the checksum-update stage: FSM states and the WAIT timer width.
// Also supplies the bus-width macros normally provided by def.svh when it is not in scope.
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 7:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 7:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 7:0
`endif

package cksum_update_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    START,
    WAIT,
    WRITE,
    OUT
  } state_t;

  localparam int TMR_W = 8;
endpackage

// File: rtl/cksum.sv
// Internet checksum engine: one's-complement sum of 16-bit big-endian words
// over hdr[field_start +: field_len], one word per cycle; result is ~sum.
module cksum
  import cksum_update_pkg::*;
#(
  parameter int HDR_LEN = `HDR_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [HDR_LEN*8-1:0] hdr,
  input  logic [`ADDR_BUS]     field_start,
  input  logic [`DATA_BUS]     field_len,
  output logic                 ready,
  output logic [15:0]          val
);

  logic             busy;
  logic [`ADDR_BUS] ptr;
  logic [`ADDR_BUS] ptr_lo;
  logic [`DATA_BUS] left;
  logic [15:0]      acc;
  logic [15:0]      word;

  // End-around-carry addition keeps the accumulator in 16 bits.
  function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [7:0] byte_at(input logic [HDR_LEN*8-1:0] h,
                                         input logic [`ADDR_BUS] idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < HDR_LEN; i++) begin
      if (int'(idx) == i) b = h[i*8 +: 8];
    end
    return b;
  endfunction

  always_comb begin
    ptr_lo = ptr + 8'd1;
    word   = {byte_at(hdr, ptr), byte_at(hdr, ptr_lo)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      ready <= 1'b1;
      val   <= '0;
      ptr   <= '0;
      left  <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      ready <= 1'b0;
      ptr   <= field_start;
      left  <= field_len;
      acc   <= '0;
    end else if (busy) begin
      if (left == '0) begin
        busy  <= 1'b0;
        ready <= 1'b1;
        val   <= ~acc;
      end else begin
        acc  <= add1c(acc, word);
        ptr  <= ptr + 8'd2;
        left <= left - 8'd2;
      end
    end
  end

endmodule

// File: rtl/cksum_update.sv
// Checksum-update stage: validates the slot/field, zeroes the slot, runs cksum
// and writes the result big-endian. Optional verify mode: CKSUM_UPDATE_VERIFY_EN.
module cksum_update
  import cksum_update_pkg::*;
#(
  parameter int HDR_LEN     = `HDR_MAX_LEN,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [HDR_LEN*8-1:0] pkt_hdr_i,
  input  logic [`ADDR_BUS]     field_start_i,
  input  logic [`DATA_BUS]     field_len_i,
  input  logic [`ADDR_BUS]     cksum_pos_i,
`ifdef CKSUM_UPDATE_VERIFY_EN
  input  logic                 verify_i,
  output logic                 bad_o,
`endif
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [HDR_LEN*8-1:0] pkt_hdr_o,
  output logic                 err_o
);

  state_t               state, state_nxt;
  logic [HDR_LEN*8-1:0] hdr_q;
  logic [`ADDR_BUS]     fs_q;
  logic [`DATA_BUS]     fl_q;
  logic [`ADDR_BUS]     pos_q;
  logic                 err_q;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic                 timeout;
  logic                 cks_kill;
  logic                 cks_start;
  logic                 cks_ready;
  logic [15:0]          cks_val;
  logic                 chk_fail;
  logic                 upd_in, upd_q;

`ifdef CKSUM_UPDATE_VERIFY_EN
  logic verify_q;
  logic bad_q;
  assign upd_in = ~verify_i;
  assign upd_q  = ~verify_q;
  assign bad_o  = bad_q;
`else
  assign upd_in = 1'b1;
  assign upd_q  = 1'b1;
`endif

  assign ready_o   = (state == IDLE) && rst;
  assign valid_o   = (state == OUT);
  assign pkt_hdr_o = hdr_q;
  assign err_o     = err_q;

  // Slot must be a 2-byte window fully inside an even-length, in-bounds field.
  always_comb begin
    chk_fail = field_len_i[0]
            || (field_len_i == '0)
            || (int'(field_start_i) + int'(field_len_i) > HDR_LEN)
            || (int'(cksum_pos_i) + 1 >= HDR_LEN)
            || (int'(cksum_pos_i) < int'(field_start_i))
            || (int'(cksum_pos_i) > int'(field_start_i) + int'(field_len_i) - 2);
  end

  always_comb begin
    timer_nxt = timer + 1'b1;
    timeout   = (timer_nxt == TMR_W'(TIMEOUT_CYC));
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cks_start = 1'b0;
    case (state)
      IDLE:  if (valid_i) state_nxt = chk_fail ? OUT : (upd_in ? ZERO : START);
      ZERO:  state_nxt = START;
      START: begin
        cks_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cks_ready)    state_nxt = WRITE;
        else if (timeout) state_nxt = OUT;
      end
      WRITE: state_nxt = OUT;
      OUT:   if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_q    <= '0;
      fs_q     <= '0;
      fl_q     <= '0;
      pos_q    <= '0;
      err_q    <= 1'b0;
      timer    <= '0;
      cks_kill <= 1'b0;
    end else begin
      cks_kill <= 1'b0;
      case (state)
        IDLE: if (valid_i) begin
          hdr_q <= pkt_hdr_i;
          fs_q  <= field_start_i;
          fl_q  <= field_len_i;
          pos_q <= cksum_pos_i;
          err_q <= chk_fail;
        end
        ZERO: for (int i = 0; i < HDR_LEN; i++) begin
          if (i == int'(pos_q) || i == int'(pos_q) + 1) hdr_q[i*8 +: 8] <= 8'h00;
        end
        START: timer <= '0;
        WAIT: begin
          timer <= timer_nxt;
          if (!cks_ready && timeout) begin
            err_q    <= 1'b1;
            cks_kill <= 1'b1;
          end
        end
        WRITE: if (upd_q) begin
          for (int i = 0; i < HDR_LEN; i++) begin
            if (i == int'(pos_q))     hdr_q[i*8 +: 8] <= cks_val[15:8];
            if (i == int'(pos_q) + 1) hdr_q[i*8 +: 8] <= cks_val[7:0];
          end
        end
        OUT: if (ready_i) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CKSUM_UPDATE_VERIFY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      verify_q <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (valid_i) begin
          verify_q <= verify_i;
          bad_q    <= 1'b0;
        end
        WRITE: bad_q <= verify_q && (cks_val != 16'h0000);
        OUT:   if (ready_i) bad_q <= 1'b0;
        default: ;
      endcase
    end
  end
`endif

  // A timed-out engine is flushed for one cycle so it is idle for the next packet.
  cksum #(
    .HDR_LEN(HDR_LEN)
  ) u_cksum (
    .clk        (clk),
    .rst        (~rst | cks_kill),
    .start      (cks_start),
    .hdr        (hdr_q),
    .field_start(fs_q),
    .field_len  (fl_q),
    .ready      (cks_ready),
    .val        (cks_val)
  );

endmodule

// File: tb/tb_cksum_update.sv
// Randomized self-checking bench for cksum_update against a behavioural
// checksum model; verify-mode cases are built when CKSUM_UPDATE_VERIFY_EN is set.
module tb_cksum_update;
  localparam int HL = 64;
  localparam int HB = HL * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [HB-1:0] pkt_hdr_i = '0;
  logic [7:0]    field_start_i = '0;
  logic [7:0]    field_len_i = '0;
  logic [7:0]    cksum_pos_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [HB-1:0] pkt_hdr_o;
  logic          err_o;
`ifdef CKSUM_UPDATE_VERIFY_EN
  logic          verify_i = 1'b0;
  logic          bad_o;
`endif

  always #5 clk = ~clk;

  cksum_update #(.HDR_LEN(HL), .TIMEOUT_CYC(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .pkt_hdr_i    (pkt_hdr_i),
    .field_start_i(field_start_i),
    .field_len_i  (field_len_i),
    .cksum_pos_i  (cksum_pos_i),
`ifdef CKSUM_UPDATE_VERIFY_EN
    .verify_i     (verify_i),
    .bad_o        (bad_o),
`endif
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .pkt_hdr_o    (pkt_hdr_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic [HB-1:0] hdr;
    bit            err;
    bit            bad;
    int            acc;
    int            lat;
    bit            seen;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   n_xfer = 0;
  int   n_sent = 0;
  int   hold = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.cks_start) n_start <= n_start + 1;
  end

  task automatic chk(input string nm, input logic [HB-1:0] act, input logic [HB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gb(input logic [HB-1:0] h, input int i);
    return h[i*8 +: 8];
  endfunction

  // Reference: validity rules, then RFC 1071 sum over the field with the slot zeroed.
  function automatic void model(input logic [HB-1:0] h, input int fs, input int fl,
                                input int pos, input bit ver,
                                output logic [HB-1:0] ho, output bit err, output bit bad);
    logic [HB-1:0] w;
    int sum;
    ho  = h;
    bad = 1'b0;
    err = (fl % 2 != 0) || (fl == 0) || (fs + fl > HL) || (pos + 1 >= HL)
       || (pos < fs) || (pos > fs + fl - 2);
    if (err) return;
    w = h;
    if (!ver) begin
      w[pos*8 +: 8]     = 8'h00;
      w[(pos+1)*8 +: 8] = 8'h00;
    end
    sum = 0;
    for (int k = fs; k < fs + fl; k += 2) sum += {gb(w, k), gb(w, k + 1)};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = ~sum & 32'hFFFF;
    if (ver) bad = (sum != 0);
    else begin
      ho = w;
      ho[pos*8 +: 8]     = sum[15:8];
      ho[(pos+1)*8 +: 8] = sum[7:0];
    end
  endfunction

  // Compare process: every cycle valid_o is high, output must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_o) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_valid: got valid_o=1 required 0 (nothing outstanding)");
        end else begin
          chk("hdr", pkt_hdr_o, q[0].hdr);
          chk("err", HB'(err_o), HB'(q[0].err));
`ifdef CKSUM_UPDATE_VERIFY_EN
          chk("bad", HB'(bad_o), HB'(q[0].bad));
`endif
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            n_cmp++;
            if (cyc - q[0].acc > q[0].lat) begin
              n_bad++;
              $display("FAIL latency: got %0d cycles required <= %0d", cyc - q[0].acc, q[0].lat);
            end
          end
        end
      end
      if (hold > 0) begin
        ready_i = 1'b0;
        if (valid_o) hold--;
      end else begin
        ready_i = ($urandom_range(0, 3) != 0);
      end
      if (valid_o && ready_i && q.size() > 0) begin
        void'(q.pop_front());
        n_xfer++;
      end
    end
  end

  task automatic send(input logic [HB-1:0] h, input int fs, input int fl, input int pos,
                      input bit ver);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    model(h, fs, fl, pos, ver, e.hdr, e.err, e.bad);
    e.lat  = e.err ? 2 : (fl / 2 + 8);
    e.seen = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (ready_o) begin
        pkt_hdr_i     = h;
        field_start_i = fs[7:0];
        field_len_i   = fl[7:0];
        cksum_pos_i   = pos[7:0];
`ifdef CKSUM_UPDATE_VERIFY_EN
        verify_i      = ver;
`endif
        valid_i       = 1'b1;
        e.acc         = cyc + 1;
        q.push_back(e);
        n_sent++;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got ready_o=0 for 400 cycles required 1");
    end
    @(negedge clk);
    valid_i = 1'b0;
    for (int k = 0; k < HL; k++) pkt_hdr_i[k*8 +: 8] = 8'($urandom);
    field_start_i = 8'($urandom);
    field_len_i   = 8'($urandom);
    cksum_pos_i   = 8'($urandom);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0 && ready_o) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d outstanding required 0", q.size());
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: got valid_o=0 for 100 cycles required 1");
    end
  endtask

  logic [7:0]    ip[20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                            8'h40, 8'h11, 8'hAA, 8'hBB, 8'hC0, 8'hA8, 8'h00, 8'h01,
                            8'hC0, 8'hA8, 8'h00, 8'hC7};
  logic [HB-1:0] ip_hdr;
  logic [HB-1:0] mh;
  bit            me, mb;
  int            st0;

  initial begin
    ip_hdr = '0;
    for (int k = 0; k < 20; k++) ip_hdr[k*8 +: 8] = ip[k];

    // Pin the model with the hand-computed IPv4 checksum.
    model(ip_hdr, 0, 20, 10, 1'b0, mh, me, mb);
    chk("model_b10", HB'(mh[87:80]), HB'(8'hB8));
    chk("model_b11", HB'(mh[95:88]), HB'(8'h61));
    chk("model_err", HB'(me), HB'(1'b0));

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", HB'(ready_o), '0);
    chk("rst_valid", HB'(valid_o), '0);
    chk("rst_err", HB'(err_o), '0);
    chk("rst_hdr", pkt_hdr_o, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", HB'(ready_o), HB'(1'b1));

    // IPv4 golden packet.
    send(ip_hdr, 0, 20, 10, 1'b0);
    wait_valid();
    chk("ip_b10", HB'(pkt_hdr_o[87:80]), HB'(8'hB8));
    chk("ip_b11", HB'(pkt_hdr_o[95:88]), HB'(8'h61));
    chk("ip_err", HB'(err_o), '0);
    drain();

    // Back-pressure: ready_i low for 5 valid cycles.
    hold = 5;
    send(ip_hdr, 0, 20, 10, 1'b0);
    drain();
    @(negedge clk);
    chk("bp_ready_back", HB'(ready_o), HB'(1'b1));

    // Odd length: error, header unchanged, no engine start.
    st0 = n_start;
    send(ip_hdr, 0, 19, 10, 1'b0);
    drain();
    chk("odd_no_start", HB'(n_start), HB'(st0));

    // Slot outside the field.
    st0 = n_start;
    send(ip_hdr, 0, 20, 30, 1'b0);
    drain();
    chk("pos30_no_start", HB'(n_start), HB'(st0));

    // Reset while waiting on the engine, then the same packet again.
    send(ip_hdr, 0, 20, 10, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_sent -= q.size();
    q.delete();
    @(negedge clk);
    chk("midrst_valid", HB'(valid_o), '0);
    chk("midrst_hdr", pkt_hdr_o, '0);
    chk("midrst_ready", HB'(ready_o), '0);
    rst = 1'b1;
    send(ip_hdr, 0, 20, 10, 1'b0);
    wait_valid();
    chk("post_rst_b10", HB'(pkt_hdr_o[87:80]), HB'(8'hB8));
    chk("post_rst_b11", HB'(pkt_hdr_o[95:88]), HB'(8'h61));
    drain();

`ifdef CKSUM_UPDATE_VERIFY_EN
    mh = ip_hdr;
    mh[87:80] = 8'hB8;
    mh[95:88] = 8'h61;
    send(mh, 0, 20, 10, 1'b1);
    wait_valid();
    chk("verify_good", HB'(bad_o), '0);
    drain();
    mh[87:80] = 8'hB9;
    send(mh, 0, 20, 10, 1'b1);
    wait_valid();
    chk("verify_bad", HB'(bad_o), HB'(1'b1));
    drain();
`endif

    // Randomized packets: mostly legal windows, some arbitrary parameters.
    for (int n = 0; n < 60; n++) begin
      logic [HB-1:0] h;
      int fs, fl, pos;
      bit ver;
      for (int k = 0; k < HL; k++) h[k*8 +: 8] = 8'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        fl  = 2 * $urandom_range(1, HL / 2);
        fs  = $urandom_range(0, HL - fl);
        pos = $urandom_range(fs, fs + fl - 2);
      end else begin
        fs  = $urandom_range(0, 80);
        fl  = $urandom_range(0, 80);
        pos = $urandom_range(0, 80);
      end
`ifdef CKSUM_UPDATE_VERIFY_EN
      ver = $urandom_range(0, 1) != 0;
`else
      ver = 1'b0;
`endif
      if ($urandom_range(0, 4) == 0) hold = $urandom_range(1, 4);
      send(h, fs, fl, pos, ver);
    end
    drain();
    chk("xfer_count", HB'(n_xfer), HB'(n_sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cksum_update.md
Name: cksum_update

Overview:
- Controller stage directly upstream of the `cksum` unit; owns one `cksum` instance.
- Flow: accept a parsed header, zero the 2-byte checksum slot, launch `cksum` over the covered field, and wait for its result.
- Then write the result big-endian into the slot and hand the updated header downstream.
- Sits between the header parser and the deparser/egress stage.

Parameters:
- HDR_LEN, default `HDR_MAX_LEN, header buffer depth in bytes.
- TIMEOUT_CYC, default 255, maximum cycles spent in WAIT before error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- valid_i  in  1  upstream header valid.
- ready_o  out  1  block can accept (high only in IDLE).
- pkt_hdr_i  in  `BYTE_BUS x HDR_LEN  header bytes.
- field_start_i  in  `ADDR_BUS  first byte covered by the checksum.
- field_len_i  in  `DATA_BUS  byte count covered.
- cksum_pos_i  in  `ADDR_BUS  offset of the 2-byte checksum slot.
- valid_o  out  1  updated header valid.
- ready_i  in  1  downstream accept.
- pkt_hdr_o  out  `BYTE_BUS x HDR_LEN  updated header.
- err_o  out  1  qualifies valid_o: header passed unchanged because of an error.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; ready_o=0 during reset, 1 thereafter in IDLE.
  - valid_o=0, err_o=0, header register all zero, timer=0.
  - Internal `cksum` is held in reset via an inverted rst.
- IDLE: ready_o=1. On valid_i&&ready_o, latch header, field_start, field_len and pos, then check:
  - field_len odd, or field_len==0;
  - field_start+field_len > HDR_LEN;
  - pos+1 >= HDR_LEN;
  - pos outside [field_start, field_start+field_len-2].
  - Any check fails -> OUT with err_o=1 and header unmodified. Otherwise -> ZERO.
- ZERO (1 cycle): hdr[pos]=0, hdr[pos+1]=0 -> START.
- START (1 cycle):
  - Pulse `cksum` start for exactly one cycle.
  - Drive `cksum` with the latched header and field -> WAIT.
  - Timer cleared.
- WAIT:
  - On `cksum` ready -> WRITE. `cksum` ready is already low on the first WAIT cycle because `cksum` clears it on start.
  - Timer increments each cycle; reaching TIMEOUT_CYC -> OUT with err_o=1 and header as latched (slot zeroed).
  - `cksum` is then reset for one cycle before IDLE.
- WRITE (1 cycle): hdr[pos]=val[15:8], hdr[pos+1]=val[7:0] -> OUT.
- OUT:
  - valid_o=1, pkt_hdr_o and err_o stable until ready_i.
  - On valid_o&&ready_i -> IDLE; valid_o and err_o drop next cycle.
  - ready_i may be held high beforehand: the transfer still occurs in the first OUT cycle.
- No back-to-back accept: minimum one IDLE cycle between packets.
- valid_i is ignored outside IDLE; upstream must hold it.
- Reset mid-operation: abandon the packet, no output, same values as reset.
- Latency: accept to valid_o is at most field_len/2 + 8 cycles with no errors.

Optional Feature:
- Macro CKSUM_UPDATE_VERIFY_EN adds input verify_i (latched with the header) and output bad_o (reset 0).
- With verify_i=1:
  - ZERO is skipped; the existing slot is summed.
  - WRITE leaves the header untouched.
  - bad_o=1 at OUT if the result != 16'h0000.
- Without the macro: no verify_i/bad_o ports; always update mode.

Decomposition:
- Shared package: the state enum (IDLE, ZERO, START, WAIT, WRITE, OUT) and the timeout counter width.
- Bus widths continue to come from def.svh.
- Sub-module: the existing `cksum` instance only; no further split.

Test Plan:
- IPv4 header, 20 bytes: 45 00 00 73 00 00 40 00 40 11 AA BB C0 A8 00 01 C0 A8 00 C7; field_start=0, len=20, pos=10 -> valid_o with bytes 10..11 = B8 61, err_o=0, all other bytes unchanged.
- Same packet with ready_i held low for 5 cycles in OUT -> valid_o and header stable throughout; single transfer; then ready_o returns to 1.
- field_len=19 -> OUT within 2 cycles, err_o=1, header byte-identical to input.
- pos=30 with field 0..19 -> err_o=1, no `cksum` start pulse observed.
- rst low during WAIT, then a new packet with the same IPv4 input -> first output is that packet's correct B8 61 with no stale valid_o.
- Under CKSUM_UPDATE_VERIFY_EN, verify_i=1 on the header carrying B8 61 -> bad_o=0; the same header with byte 10=B9 -> bad_o=1.
